// File: rtl/profile_pkg.sv
// Shared definitions for the profiling-counter command controller:
// opcode values, FSM state encoding and default bank geometry.
package profile_pkg;

   localparam int DEFAULT_NUM_CNT = 4;
   localparam int DEFAULT_WIDTH   = 32;

   // Width of the custom-instruction operand and result buses.
   localparam int CI_WIDTH = 32;

   // Bit position of channel 0's overflow flag in the STATUS word.
   localparam int OVF_LSB = 8;

   localparam logic [2:0] OP_READ   = 3'd0;
   localparam logic [2:0] OP_START  = 3'd1;
   localparam logic [2:0] OP_STOP   = 3'd2;
   localparam logic [2:0] OP_CLEAR  = 3'd3;
   localparam logic [2:0] OP_STATUS = 3'd4;
   localparam logic [2:0] OP_DIR    = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

endpackage

// File: rtl/profile_ovf_detect.sv
// Per-channel wrap detector for one profiling counter. Keeps the previous
// sampled counter value and raises a sticky overflow flag when an enabled
// counter wraps in its counting direction (all-ones -> 0 going up,
// 0 -> all-ones going down). The flag is cleared by a CLEAR on the channel.
module profile_ovf_detect #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             direction,
   input  logic             clear,
   input  logic [WIDTH-1:0] value,
   output logic             overflow
);

   logic [WIDTH-1:0] prev_q;
   logic             wrap;

   // Compare last cycle's value with this cycle's value for a wrap.
   always_comb begin
      // NOTE: every variable driven here gets a default first so no latch is inferred.
      wrap = 1'b0;
      if (enable) begin
         if (direction) begin
            wrap = (prev_q == '1) && (value == '0);
         end else begin
            wrap = (prev_q == '0) && (value == '1);
         end
      end
   end

   // Track the previous value and hold the sticky flag; a clear wins over a
   // wrap seen in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_q   <= '0;
         overflow <= 1'b0;
      end else begin
         prev_q <= value;
         if (clear) begin
            overflow <= 1'b0;
         end else if (wrap) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/profile_counter_ctrl.sv
// Command-side controller for the profiling counter bank.
// Decodes single-cycle custom-instruction requests into per-channel enable,
// direction and clear controls, and returns sampled counter values.
// Optional feature: define PROFILE_CNT_OVF_EN to add per-channel sticky
// overflow flags, reported in STATUS bits [8 +: NUM_CNT]; without it those
// bits read 0 and no sampling registers exist.
module profile_counter_ctrl
   import profile_pkg::*;
#(
   parameter int NUM_CNT = DEFAULT_NUM_CNT,
   parameter int WIDTH   = DEFAULT_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     ciStart,
   input  logic [CI_WIDTH-1:0]      ciValueA,
   input  logic [CI_WIDTH-1:0]      ciValueB,
   output logic                     ciDone,
   output logic [CI_WIDTH-1:0]      ciResult,
   output logic [NUM_CNT-1:0]       counterEnable,
   output logic [NUM_CNT-1:0]       counterDirection,
   output logic [NUM_CNT-1:0]       counterReset,
   input  logic [NUM_CNT*WIDTH-1:0] counterValues
);

   state_t              state;
   logic [2:0]          opcode;
   logic [NUM_CNT-1:0]  mask;
   logic                accept;
   logic [2:0]          read_idx_q;
   logic [WIDTH-1:0]    read_value;
   logic [CI_WIDTH-1:0] status_word;
   logic [NUM_CNT-1:0]  ovf_flags;
   logic                unused_ci_bits;

   // Only the opcode field of A and the low bits of B carry meaning; mask
   // bits at or above NUM_CNT simply fall outside the slice.
   assign opcode = ciValueA[2:0];
   assign mask   = ciValueB[NUM_CNT-1:0];
   assign accept = ciStart && (state == ST_IDLE);

   assign unused_ci_bits = ^{ciValueA[CI_WIDTH-1:3], ciValueB};

   // Select the latched channel's value; indices past the bank return 0.
   always_comb begin
      read_value = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (int'(read_idx_q) == i) begin
            read_value = counterValues[i*WIDTH +: WIDTH];
         end
      end
   end

   // Assemble the STATUS word: enables in the low bits, overflow flags above.
   always_comb begin
      status_word                      = '0;
      status_word[NUM_CNT-1:0]         = counterEnable;
      status_word[OVF_LSB +: NUM_CNT]  = ovf_flags;
   end

`ifdef PROFILE_CNT_OVF_EN
   logic [NUM_CNT-1:0] ovf_clear;

   // A CLEAR command clears the overflow flag of every channel it pulses.
   assign ovf_clear = (accept && (opcode == OP_CLEAR)) ? mask : '0;

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_ovf
      profile_ovf_detect #(
         .WIDTH(WIDTH)
      ) u_ovf_detect (
         .clock     (clock),
         .reset     (reset),
         .enable    (counterEnable[i]),
         .direction (counterDirection[i]),
         .clear     (ovf_clear[i]),
         .value     (counterValues[i*WIDTH +: WIDTH]),
         .overflow  (ovf_flags[i])
      );
   end
`else
   assign ovf_flags = '0;
`endif

   // Command FSM with registered controls and response. Control effects of a
   // command land on the accepting edge; READ spends one extra cycle in
   // CAPTURE so the value is sampled the cycle after acceptance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         counterEnable    <= '0;
         counterDirection <= '1;
         counterReset     <= '0;
         ciDone           <= 1'b0;
         ciResult         <= '0;
         read_idx_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register reads pre-edge values.
         counterReset <= '0;
         ciDone       <= 1'b0;
         ciResult     <= '0;

         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (opcode == OP_READ) begin
                     read_idx_q <= ciValueB[2:0];
                     state      <= ST_CAPTURE;
                  end else begin
                     ciDone <= 1'b1;
                     state  <= ST_RESPOND;
                     case (opcode)
                        OP_START:  counterEnable    <= counterEnable | mask;
                        OP_STOP:   counterEnable    <= counterEnable & ~mask;
                        OP_CLEAR:  counterReset     <= mask;
                        OP_STATUS: ciResult         <= status_word;
                        OP_DIR:    counterDirection <= mask;
                        default:   ;
                     endcase
                  end
               end
            end

            ST_CAPTURE: begin
               ciResult <= CI_WIDTH'(read_value);
               ciDone   <= 1'b1;
               state    <= ST_RESPOND;
            end

            ST_RESPOND: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_profile_counter_ctrl.sv
// Self-checking bench for profile_counter_ctrl (NUM_CNT=4, WIDTH=8).
// A bank of behavioural counters drives counterValues from the DUT's
// controls. A command-level model predicts every output each cycle; directed
// sequences pin that model with literal expectations, then random traffic
// (including mid-command resets and preloads near the wrap points) runs.
module tb_profile_counter_ctrl;

   localparam int NUM_CNT = 4;
   localparam int WIDTH   = 8;

   localparam logic [2:0] C_READ   = 3'd0;
   localparam logic [2:0] C_START  = 3'd1;
   localparam logic [2:0] C_STOP   = 3'd2;
   localparam logic [2:0] C_CLEAR  = 3'd3;
   localparam logic [2:0] C_STATUS = 3'd4;
   localparam logic [2:0] C_DIR    = 3'd5;

`ifdef PROFILE_CNT_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic                     clock = 1'b0;
   logic                     reset = 1'b0;
   logic                     ciStart = 1'b0;
   logic [31:0]              ciValueA = '0;
   logic [31:0]              ciValueB = '0;
   logic                     ciDone;
   logic [31:0]              ciResult;
   logic [NUM_CNT-1:0]       counterEnable;
   logic [NUM_CNT-1:0]       counterDirection;
   logic [NUM_CNT-1:0]       counterReset;
   logic [NUM_CNT*WIDTH-1:0] counterValues;

   int n_vec = 0;
   int n_err = 0;

   profile_counter_ctrl #(
      .NUM_CNT(NUM_CNT),
      .WIDTH  (WIDTH)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .ciStart          (ciStart),
      .ciValueA         (ciValueA),
      .ciValueB         (ciValueB),
      .ciDone           (ciDone),
      .ciResult         (ciResult),
      .counterEnable    (counterEnable),
      .counterDirection (counterDirection),
      .counterReset     (counterReset),
      .counterValues    (counterValues)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- counter bank environment ----------------
   logic [WIDTH-1:0] cnt [NUM_CNT] = '{default: '0};
   logic             load_req = 1'b0;
   int               load_idx = 0;
   logic [WIDTH-1:0] load_val = '0;

   always_comb begin
      counterValues = '0;
      for (int i = 0; i < NUM_CNT; i++) counterValues[i*WIDTH +: WIDTH] = cnt[i];
   end

   always @(posedge clock) begin
      for (int i = 0; i < NUM_CNT; i++) begin
         if (load_req && load_idx == i)  cnt[i] <= load_val;
         else if (counterReset[i])       cnt[i] <= '0;
         else if (counterEnable[i])      cnt[i] <= counterDirection[i] ? cnt[i] + WIDTH'(1) : cnt[i] - WIDTH'(1);
      end
   end

   // ---------------- command-level reference model ----------------
   // Edges are numbered from the last reset; "X_edge == edge_no" means the
   // event is visible during the cycle following that edge.
   int                 edge_no    = 0;
   int                 ready_edge = 0;
   int                 done_edge  = -1;
   int                 read_edge  = -1;
   int                 clr_edge   = -1;
   int                 read_idx   = 0;
   logic [31:0]        exp_result = '0;
   logic [NUM_CNT-1:0] clr_mask   = '0;
   logic [NUM_CNT-1:0] m_en       = '0;
   logic [NUM_CNT-1:0] m_dir      = '1;
   logic [NUM_CNT-1:0] m_ovf      = '0;
   logic [WIDTH-1:0]   m_prev [NUM_CNT] = '{default: '0};

   always @(posedge clock or negedge reset) begin
      logic [NUM_CNT-1:0] new_ovf;
      logic [NUM_CNT-1:0] mask;
      if (!reset) begin
         edge_no = 0; ready_edge = 0; done_edge = -1; read_edge = -1; clr_edge = -1;
         exp_result = '0; clr_mask = '0;
         m_en = '0; m_dir = '1; m_ovf = '0;
         for (int i = 0; i < NUM_CNT; i++) m_prev[i] = '0;
      end else begin
         edge_no++;
         new_ovf = m_ovf;
         for (int i = 0; i < NUM_CNT; i++) begin
            if (OVF_EN && m_en[i] &&
                ((m_dir[i] && m_prev[i] == '1 && cnt[i] == '0) ||
                 (!m_dir[i] && m_prev[i] == '0 && cnt[i] == '1)))
               new_ovf[i] = 1'b1;
            m_prev[i] = cnt[i];
         end
         if (edge_no == read_edge) begin
            exp_result = (read_idx < NUM_CNT) ? 32'(cnt[read_idx]) : 32'd0;
            done_edge  = edge_no;
         end
         if (ciStart && edge_no >= ready_edge) begin
            mask = ciValueB[NUM_CNT-1:0];
            if (ciValueA[2:0] == C_READ) begin
               read_idx   = int'(ciValueB[2:0]);
               read_edge  = edge_no + 1;
               ready_edge = edge_no + 3;
            end else begin
               done_edge  = edge_no;
               ready_edge = edge_no + 2;
               exp_result = '0;
               case (ciValueA[2:0])
                  C_START:  m_en = m_en | mask;
                  C_STOP:   m_en = m_en & ~mask;
                  C_CLEAR:  begin clr_edge = edge_no; clr_mask = mask; new_ovf = new_ovf & ~mask; end
                  C_STATUS: exp_result = 32'(m_en) | (32'(m_ovf) << 8);
                  C_DIR:    m_dir = mask;
                  default:  ;
               endcase
            end
         end
         m_ovf = new_ovf;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         check("done",   32'(ciDone),           32'(done_edge == edge_no));
         check("result", ciResult,              (done_edge == edge_no) ? exp_result : 32'd0);
         check("enable", 32'(counterEnable),    32'(m_en));
         check("dir",    32'(counterDirection), 32'(m_dir));
         check("creset", 32'(counterReset),     (clr_edge == edge_no) ? 32'(clr_mask) : 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_cmd(input logic [2:0] op, input logic [31:0] b,
                         output logic [31:0] res, output logic [NUM_CNT-1:0] rst_at_done);
      logic got;
      int   lat;
      @(negedge clock); #1;
      ciStart  = 1'b1;
      ciValueA = {29'($urandom), op};
      ciValueB = b;
      got = 1'b0; lat = 0; res = '0; rst_at_done = '0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clock);
         if (ciDone === 1'b1) begin
            got = 1'b1; lat = k; res = ciResult; rst_at_done = counterReset;
         end
         #1 ciStart = 1'b0;
      end
      check("cmd_done_seen", 32'(got), 32'd1);
      if (got) check("cmd_latency", 32'(lat), (op == C_READ) ? 32'd1 : 32'd0);
   endtask

   task automatic preload(input int idx, input logic [WIDTH-1:0] v);
      @(negedge clock); #1;
      load_req = 1'b1; load_idx = idx; load_val = v;
      @(negedge clock); #1;
      load_req = 1'b0;
   endtask

   initial begin
      logic [31:0]        res;
      logic [NUM_CNT-1:0] rd;
      int                 ndone;

      // Reset values, then quiet idle.
      repeat (3) @(negedge clock);
      check("rst_enable", 32'(counterEnable),    32'h0);
      check("rst_dir",    32'(counterDirection), 32'hF);
      check("rst_done",   32'(ciDone),           32'h0);
      check("rst_result", ciResult,              32'h0);
      #1 reset = 1'b1;
      repeat (5) begin
         @(negedge clock);
         check("idle_enable", 32'(counterEnable),    32'h0);
         check("idle_dir",    32'(counterDirection), 32'hF);
         check("idle_done",   32'(ciDone),           32'h0);
      end

      // START, then READ of a known value and of an out-of-range index.
      do_cmd(C_START, 32'hFFFF_FFF5, res, rd);
      check("start_result", res, 32'h0);
      check("start_enable", 32'(counterEnable), 32'h5);
      do_cmd(C_STOP, 32'hF, res, rd);
      check("stop_enable", 32'(counterEnable), 32'h0);
      preload(2, 8'hA5);
      do_cmd(C_READ, 32'h2, res, rd);
      check("read_ch2", res, 32'h0000_00A5);
      do_cmd(C_READ, 32'h6, res, rd);
      check("read_idx6", res, 32'h0);

      // CLEAR while counting: one-cycle pulse, enables untouched.
      do_cmd(C_START, 32'h2, res, rd);
      do_cmd(C_CLEAR, 32'h2, res, rd);
      check("clear_pulse", 32'(rd), 32'h2);
      check("clear_enable", 32'(counterEnable), 32'h2);
      @(negedge clock);
      check("clear_pulse_end", 32'(counterReset), 32'h0);

      // ciStart held for four edges: two commands accepted.
      @(negedge clock); #1;
      ciStart = 1'b1; ciValueA = 32'(C_STOP); ciValueB = 32'hF;
      ndone = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (ciDone === 1'b1) ndone++;
         if (k == 3) #1 ciStart = 1'b0;
      end
      @(negedge clock);
      if (ciDone === 1'b1) ndone++;
      check("held_done_count", 32'(ndone), 32'd2);
      check("held_enable", 32'(counterEnable), 32'h0);

      // Overflow on channel 0 counting up through 0xFF -> 0x00.
      do_cmd(C_DIR, 32'h1, res, rd);
      check("dir_set", 32'(counterDirection), 32'h1);
      preload(0, 8'hFD);
      do_cmd(C_START, 32'h1, res, rd);
      repeat (6) @(negedge clock);
      do_cmd(C_STOP, 32'h1, res, rd);
      do_cmd(C_STATUS, 32'h0, res, rd);
      check("ovf_flag_set", 32'(res[8]), 32'(OVF_EN));
      check("ovf_status_en", 32'(res[3:0]), 32'h0);
      do_cmd(C_CLEAR, 32'h1, res, rd);
      do_cmd(C_STATUS, 32'h0, res, rd);
      check("ovf_flag_clr", 32'(res[8]), 32'h0);

      // Random traffic with occasional resets and near-wrap preloads.
      for (int c = 0; c < 2500; c++) begin
         @(negedge clock); #1;
         reset    = ($urandom_range(0, 249) != 0);
         ciStart  = ($urandom_range(0, 1) == 1);
         ciValueA = $urandom;
         ciValueB = $urandom;
         load_req = ($urandom_range(0, 5) == 0);
         load_idx = $urandom_range(0, NUM_CNT - 1);
         case ($urandom_range(0, 4))
            0:       load_val = 8'h00;
            1:       load_val = 8'h01;
            2:       load_val = 8'hFE;
            3:       load_val = 8'hFF;
            default: load_val = 8'($urandom);
         endcase
      end
      @(negedge clock); #1;
      reset = 1'b1; ciStart = 1'b0; load_req = 1'b0;
      repeat (4) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/profile_counter_ctrl.md
# profile_counter_ctrl

Command-side controller for the profiling counters. It decodes single-cycle custom-instruction requests from the CPU into per-channel enable, clear and direction controls for NUM_CNT external `counter` instances. It also samples and returns their counterValue outputs. It sits between the CPU custom-instruction port and the counter bank, and is the only agent that drives counter controls.

## Interface
- NUM_CNT, 4, number of counter channels (1..8)
- WIDTH, 32, width of each counter value (8..32)
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low
- ciStart  input  1  request strobe, one cycle
- ciValueA  input  32  [2:0] opcode, rest ignored
- ciValueB  input  32  channel mask [NUM_CNT-1:0], or channel index [2:0] for reads
- ciDone  output  1  one-cycle completion pulse
- ciResult  output  32  result, valid only while ciDone=1, otherwise 0
- counterEnable  output  NUM_CNT  per-channel enable to counters
- counterDirection  output  NUM_CNT  per-channel direction (1=up)
- counterReset  output  NUM_CNT  per-channel clear pulse, active-high, one cycle
- counterValues  input  NUM_CNT*WIDTH  concatenated counter outputs, channel 0 in LSBs

## Operation
- Opcodes:
  - 0 READ: return zero-extended value of channel ciValueB[2:0]. Index ≥ NUM_CNT returns 0.
  - 1 START: counterEnable |= mask.
  - 2 STOP: counterEnable &= ~mask.
  - 3 CLEAR: pulse counterReset for mask bits. Enables are unchanged.
  - 4 STATUS: ciResult[NUM_CNT-1:0]=counterEnable, [15:8]=overflow flags (see Configuration).
  - 5 DIR: counterDirection = mask.
  - 6, 7: no effect; ciDone pulses with ciResult=0.
- Mask bits at or above NUM_CNT are ignored.
- FSM states:
  - IDLE: accepts ciStart.
  - CAPTURE: READ only; latches the selected counterValues slice.
  - RESPOND: drives ciDone and ciResult.
  - IDLE→RESPOND on a non-READ opcode; IDLE→CAPTURE on READ; CAPTURE→RESPOND; RESPOND→IDLE.
- ciStart outside IDLE is ignored. No queueing; no error flag.
- Reset (any time, including mid-command):
  - State → IDLE.
  - counterEnable=0, counterDirection=all ones, counterReset=0, ciDone=0, ciResult=0, overflow flags=0.
  - An in-flight command is dropped with no ciDone.

## Timing
- Request accepted at edge N (ciStart=1 in IDLE).
- Control effects (enable, direction, reset pulse) are registered at edge N. Counters see them from cycle N+1. counterReset is high for exactly cycle N+1.
- Non-READ commands: ciDone=1 during cycle N+1.
- READ: value sampled at edge N+1 (value as of cycle N+1), ciDone=1 during cycle N+2.
- Back-to-back: earliest next accepted ciStart is the edge after ciDone; throughput is one command per 2 cycles (3 for READ).
- CLEAR and START in consecutive commands are legal. The clear pulse and the enable rise do not interact.

## Configuration
- Macro PROFILE_CNT_OVF_EN.
- Defined:
  - Per-channel sticky overflow flag, set when the channel is enabled and its sampled value goes from all-ones to 0 (up) or from 0 to all-ones (down) between consecutive cycles.
  - The flag is cleared by CLEAR on that channel or by reset.
  - Visible via STATUS [8+i].
- Undefined: no sampling registers; STATUS [15:8] reads 0.

## Structure
- Shared package profile_pkg holds:
  - opcode localparams OP_READ..OP_DIR
  - state encoding
  - default NUM_CNT/WIDTH
- One natural sub-module: profile_ovf_detect.
  - Per-channel previous-value register and wrap compare.
  - Instantiated NUM_CNT times, only under PROFILE_CNT_OVF_EN.
- Read multiplexing and the FSM stay in the top module.

## Test plan
- Reset with reset=0 → counterEnable=0, counterDirection=4'b1111, ciDone=0, ciResult=0. Then reset=1; idle for 5 cycles → no outputs change.
- START mask=4'b0101 at edge N → counterEnable=4'b0101 from cycle N+1; ciDone=1 in cycle N+1 with ciResult=0.
- Counter model with channel 2 at 0x0000_00A5 → READ index 2 → ciDone in cycle N+2 with ciResult=0x0000_00A5. READ index 6 → ciResult=0.
- CLEAR mask=4'b0010 while enabled → counterReset=4'b0010 for exactly one cycle; counterEnable unchanged.
- ciStart held high for 4 cycles with opcode STOP mask=4'b1111 → exactly two ciDone pulses (edges N, N+2 accepted); counterEnable=0.
- With PROFILE_CNT_OVF_EN, channel 0 up and counting, WIDTH=8, value 0xFF→0x00 → STATUS returns bit 8 set; after CLEAR mask=1, STATUS bit 8=0. Same test without the macro → bit 8 reads 0.
